// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Brief    : Shared types and constants for the pipeline sequencer and the
//             load-use detector (FSM state encoding, x0 index, warm-up default).
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   // Sequencer states; explicit 2-bit encoding
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WARM     = 2'd1,
      RUN      = 2'd2,
      MEM_WAIT = 2'd3
   } state_t;

   // Architectural zero register: never a real producer
   localparam logic [4:0] REG_X0 = 5'd0;

   // Default instruction-memory settle time in cycles
   localparam int WARMUP_DEFAULT = 4;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_detect
//  Brief    : Combinational load-use hazard detection between the load in EX
//             and the source operands of the instruction in ID. Also reused by
//             the ID-stage forwarding logic.
//  Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
   import pipe_pkg::*;
(
   input  logic       ex_memrd_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   output logic       lu_o
);

   logic w_rd_valid;
   logic w_rs_match;

   // A load targeting x0 produces nothing, so it can never cause a hazard
   assign w_rd_valid = (ex_rd_i != REG_X0);
   assign w_rs_match = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
   assign lu_o       = ex_memrd_i && w_rd_valid && w_rs_match;

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Pipeline sequencer for the 5-stage core. Runs the start-up
//             warm-up, then generates stall / flush / bubble controls with
//             priority: memory wait > taken branch > load-use.
//             Optional performance counters enabled by defining the macro
//             PIPE_HAZARD_CTRL_PERF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int WARMUP = WARMUP_DEFAULT
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        run_i,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        ex_memrd_i,
   input  logic        branch_i,
   input  logic        dmem_req_i,
   input  logic        dmem_rdy_i,
   output logic        start_o,
   output logic        pc_stall_o,
   output logic        ifid_hazard_o,
   output logic        ifid_flush_o,
   output logic        idex_bubble_o,
   output logic        exmem_stall_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   // WARMUP=0 would give a zero-width counter; keep at least one bit
   localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam logic [CNT_W-1:0] c_warm_last = CNT_W'(WARMUP);

   state_t           r_state;
   logic [CNT_W-1:0] r_warm_cnt;
   logic             r_start;

   logic w_lu;
   logic w_in_run;
   logic w_mem_wait;
   logic w_req_miss;

   load_use_detect u_lu (
      .ex_memrd_i (ex_memrd_i),
      .ex_rd_i    (ex_rd_i),
      .id_rs1_i   (id_rs1_i),
      .id_rs2_i   (id_rs2_i),
      .lu_o       (w_lu)
   );

   assign w_in_run   = (r_state == RUN);
   assign w_req_miss = dmem_req_i && !dmem_rdy_i;
   // Memory is blocking either while parked in MEM_WAIT or in the request cycle itself
   assign w_mem_wait = (r_state == MEM_WAIT) || (w_in_run && w_req_miss);

   // Sequencer FSM with warm-up counter and registered run enable
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_warm_cnt <= '0;
         r_start    <= 1'b0;
      end else if (!run_i) begin
         r_state    <= IDLE;
         r_warm_cnt <= '0;
         r_start    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state    <= WARM;
               r_warm_cnt <= '0;
               r_start    <= 1'b0;
            end
            WARM: begin
               if (r_warm_cnt == c_warm_last) begin
                  r_state    <= RUN;
                  r_warm_cnt <= '0;
                  r_start    <= 1'b1;
               end else begin
                  r_warm_cnt <= r_warm_cnt + 1'b1;
               end
            end
            RUN: begin
               r_start <= 1'b1;
               if (w_req_miss) begin
                  r_state <= MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               r_start <= 1'b1;
               if (dmem_rdy_i) begin
                  r_state <= RUN;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_warm_cnt <= '0;
               r_start    <= 1'b0;
            end
         endcase
      end
   end

   assign start_o = r_start;

   // Priority mux: memory wait freezes everything, a branch kills the wrong-path
   // ID instruction (so it overrides load-use), load-use inserts one bubble
   always_comb begin
      pc_stall_o    = 1'b0;
      ifid_hazard_o = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      exmem_stall_o = 1'b0;
      if (w_mem_wait) begin
         pc_stall_o    = 1'b1;
         ifid_hazard_o = 1'b1;
         exmem_stall_o = 1'b1;
      end else if (w_in_run && branch_i) begin
         ifid_flush_o  = 1'b1;
      end else if (w_in_run && w_lu) begin
         pc_stall_o    = 1'b1;
         ifid_hazard_o = 1'b1;
         idex_bubble_o = 1'b1;
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   // Free-running event counters, wrap naturally, cleared only by reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (pc_stall_o) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (ifid_flush_o) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Directed self-checking bench for pipe_hazard_ctrl (WARMUP=4).
//             Counter checks are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic       run;
   logic [4:0] rs1, rs2, rd;
   logic       memrd, branch, req, rdy;
   logic       start, pc_stall, ifid_hazard, ifid_flush, idex_bubble, exmem_stall;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   pipe_hazard_ctrl #(.WARMUP(4)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .run_i         (run),
      .id_rs1_i      (rs1),
      .id_rs2_i      (rs2),
      .ex_rd_i       (rd),
      .ex_memrd_i    (memrd),
      .branch_i      (branch),
      .dmem_req_i    (req),
      .dmem_rdy_i    (rdy),
      .start_o       (start),
      .pc_stall_o    (pc_stall),
      .ifid_hazard_o (ifid_hazard),
      .ifid_flush_o  (ifid_flush),
      .idex_bubble_o (idex_bubble),
      .exmem_stall_o (exmem_stall)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
     ,.stall_cnt_o   (stall_cnt),
      .flush_cnt_o   (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packed view of the five control outputs: {pc, hz, flush, bubble, exmem}
   function automatic logic [31:0] ctl();
      return {27'd0, pc_stall, ifid_hazard, ifid_flush, idex_bubble, exmem_stall};
   endfunction

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0;
      rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
      memrd = 1'b0; branch = 1'b0; req = 1'b0; rdy = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("reset_start", {31'd0, start}, 32'd0);
      check("reset_ctl",   ctl(), 32'd0);

      // Warm-up: start low for 5 edges, high from the 6th
      run = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("warm_start_e%0d", i), {31'd0, start}, 32'd0);
      end
      check("warm_ctl_quiet", ctl(), 32'd0);
      tick();
      check("run_start_e6", {31'd0, start}, 32'd1);

      // Load-use on rs2: one cycle of pc_stall + hazard + bubble
      memrd = 1'b1; rd = 5'd5; rs2 = 5'd5; rs1 = 5'd1;
      #1;
      check("lu_ctl", ctl(), 32'b11010);
      tick();
      memrd = 1'b0; rd = 5'd0;       // EX now holds the bubble
      #1;
      check("lu_after_bubble", ctl(), 32'd0);

      // Load to x0 matching rs2=x0: no hazard
      memrd = 1'b1; rd = 5'd0; rs2 = 5'd0; rs1 = 5'd0;
      #1;
      check("lu_x0_none", ctl(), 32'd0);

      // Branch with a load-use match: flush only
      rd = 5'd7; rs1 = 5'd7; branch = 1'b1;
      #1;
      check("branch_over_lu", ctl(), 32'b00100);
      tick();
      memrd = 1'b0; rd = 5'd0; rs1 = 5'd0; branch = 1'b0;
      #1;
      check("branch_done", ctl(), 32'd0);

      // Memory wait of 3 cycles with a pending branch
      req = 1'b1; rdy = 1'b0; branch = 1'b1;
      #1;
      check("mw_c0", ctl(), 32'b11001);
      tick();
      #1;
      check("mw_c1", ctl(), 32'b11001);
      tick();
      rdy = 1'b1;
      #1;
      check("mw_c2_rdy", ctl(), 32'b11001);
      tick();
      req = 1'b0; rdy = 1'b0;
      #1;
      check("mw_branch_flush", ctl(), 32'b00100);
      check("mw_start_held", {31'd0, start}, 32'd1);
      tick();
      branch = 1'b0;

      // Hit in the request cycle: no stall, stays in RUN
      req = 1'b1; rdy = 1'b1;
      #1;
      check("hit_no_stall", ctl(), 32'd0);
      tick();
      req = 1'b0; rdy = 1'b0;
      #1;
      check("hit_still_run", ctl(), 32'd0);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
      check("perf_stall_cnt", stall_cnt, 32'd4);
      check("perf_flush_cnt", flush_cnt, 32'd2);
      force dut.r_stall_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_stall_cnt;
      memrd = 1'b1; rd = 5'd9; rs1 = 5'd9;
      tick();
      memrd = 1'b0; rd = 5'd0; rs1 = 5'd0;
      #1;
      check("perf_stall_wrap", stall_cnt, 32'd0);
`endif

      // run_i low: start falls at the next edge, controls quiet
      run = 1'b0;
      #1;
      check("runlow_start_pre", {31'd0, start}, 32'd1);
      tick();
      check("runlow_start_post", {31'd0, start}, 32'd0);
      run = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("rerun_start", {31'd0, start}, 32'd1);

      // Async reset in MEM_WAIT: everything drops before any clock edge
      req = 1'b1; rdy = 1'b0;
      tick();
      check("mw_before_rst", ctl(), 32'b11001);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_start", {31'd0, start}, 32'd0);
      check("async_rst_ctl", ctl(), 32'd0);
      req = 1'b0;
      tick();
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
